// File: rtl/rr_mux_reg_nx1.sv
// N_IN-to-1 registered channel mux with a valid/ready handshake.
// Grant comes from a fixed select (mode 0) or a round-robin pointer (mode 1).
module rr_mux_reg_nx1 #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_src,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int PW = SEL_W + 1;
    localparam logic [PW-1:0] N_P = PW'(N_IN);

    logic [SEL_W-1:0] rr_ptr, gnt_idx, ptr_nxt;
    logic [PW-1:0]    ptr_inc;
    logic [N_IN-1:0]  hi_mask, hi_req;
    logic [WIDTH-1:0] sel_data;
    logic             gnt_vld, load_ok, xfer;

    assign load_ok = !out_valid || out_ready;
    assign xfer    = load_ok && gnt_vld;

    // Channels at or above the pointer are searched before the wrapped-around ones.
    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        assign hi_mask[i]  = (PW'(i) >= {1'b0, rr_ptr});
        assign in_ready[i] = !reset && xfer && (gnt_idx == SEL_W'(i));
    end
    assign hi_req = in_valid & hi_mask;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            for (int i = 0; i < N_IN; i++)
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
        end else if (|hi_req) begin
            for (int i = N_IN-1; i >= 0; i--)
                if (hi_req[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
        end else begin
            for (int i = N_IN-1; i >= 0; i--)
                if (in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_IN; i++)
            if (gnt_idx == SEL_W'(i))
                sel_data = in_data[i*WIDTH +: WIDTH];
    end

    // Wrap by compare so non-power-of-2 channel counts work.
    assign ptr_inc = {1'b0, gnt_idx} + PW'(1);
    assign ptr_nxt = (ptr_inc >= N_P) ? '0 : ptr_inc[SEL_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= gnt_idx;
            if (mode)
                rr_ptr <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_reg_nx1.sv
// Directed bench for rr_mux_reg_nx1: a 4x32 instance plus a 6x32 instance
// for out-of-power-of-2 select and pointer wrap.
module tb_rr_mux_reg_nx1;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode, mode6;
    logic [1:0]  sel;
    logic [2:0]  sel6;
    logic [127:0] in_data;
    logic [191:0] in_data6;
    logic [3:0]  in_valid, in_ready;
    logic [5:0]  in_valid6, in_ready6;
    logic [31:0] out_data, out_data6;
    logic [1:0]  out_src;
    logic [2:0]  out_src6;
    logic        out_valid, out_valid6, out_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_mux_reg_nx1 #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_mux_reg_nx1 #(.WIDTH(32), .N_IN(6), .SEL_W(3)) dut6 (
        .clk(clk), .reset(reset), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_src(out_src6), .out_valid(out_valid6),
        .out_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq13 [4];
        seq13[0] = 2'd1; seq13[1] = 2'd3; seq13[2] = 2'd1; seq13[3] = 2'd3;

        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hCAFE_0000 | 32'(i);
        for (int i = 0; i < 6; i++) in_data6[i*32 +: 32] = 32'hBEEF_0000 | 32'(i);
        reset = 1'b1; mode = 1'b0; sel = 2'd0; mode6 = 1'b0; sel6 = 3'd0;
        in_valid = 4'b1111; in_valid6 = 6'h00; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        step(); step();
        in_valid = 4'b0000;
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("idle_valid", 64'(out_valid), 64'h0);
            chk("idle_ready", 64'(in_ready), 64'h0);
            chk("idle_data", 64'(out_data), 64'h0);
            step();
        end

        // 2: fixed select
        sel = 2'd2; in_valid = 4'b1111;
        #1 chk("fix_in_ready", 64'(in_ready), 64'h4);
        step();
        chk("fix_data", 64'(out_data), 64'hCAFE_0002);
        chk("fix_src", 64'(out_src), 64'h2);
        chk("fix_valid", 64'(out_valid), 64'h1);
        in_valid = 4'b0000;
        step();
        chk("drain_valid", 64'(out_valid), 64'h0);
        chk("drain_hold", 64'(out_data), 64'hCAFE_0002);

        sel6 = 3'd7; in_valid6 = 6'h3F;
        #1 chk("sel6_oor", 64'(in_ready6), 64'h0);
        sel6 = 3'd5;
        #1 chk("sel6_ready", 64'(in_ready6), 64'h20);
        step();
        chk("sel6_src", 64'(out_src6), 64'h5);
        chk("sel6_data", 64'(out_data6), 64'hBEEF_0005);
        mode6 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rr6_src", 64'(out_src6), 64'(i % 6));
        end
        in_valid6 = 6'h00;

        // 3: round-robin fairness
        mode = 1'b1; in_valid = 4'b1111;
        #1 chk("rr_in_ready", 64'(in_ready), 64'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_src", 64'(out_src), 64'(i % 4));
            chk("rr_valid", 64'(out_valid), 64'h1);
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr13_src", 64'(out_src), 64'(seq13[i]));
        end

        // 4: backpressure
        in_valid = 4'b1111;
        step();
        chk("bp_first", 64'(out_src), 64'h0);
        out_ready = 1'b0;
        #1 chk("bp_in_ready0", 64'(in_ready), 64'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_data", 64'(out_data), 64'hCAFE_0000);
            chk("bp_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", 64'(in_ready), 64'h2);
        step();
        chk("bp_next_src", 64'(out_src), 64'h1);
        chk("bp_next_data", 64'(out_data), 64'hCAFE_0001);
        step();
        chk("bp_after_src", 64'(out_src), 64'h2);

        // 5: async reset between edges
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_data", 64'(out_data), 64'h0);
        chk("arst_ready", 64'(in_ready), 64'h0);
        step();
        reset = 1'b0;
        #1 chk("arst_grant", 64'(in_ready), 64'h1);
        step();
        chk("arst_src", 64'(out_src), 64'h0);

        // 6: out-of-range fixed select, then switch to round-robin
        mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        #1 chk("oor_ready", 64'(in_ready), 64'h0);
        step();
        chk("oor_valid", 64'(out_valid), 64'h0);
        chk("oor_hold", 64'(out_data), 64'hCAFE_0000);
        mode = 1'b1;
        #1 chk("sw_ready", 64'(in_ready), 64'h2);
        step();
        chk("sw_src", 64'(out_src), 64'h1);
        chk("sw_valid", 64'(out_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_mux_reg_nx1.md
Name: rr_mux_reg_nx1

Overview:
- Parametrised successor to the fixed 4-to-1 32-bit datapath mux.
- Selects one of N_IN WIDTH-bit channels and registers the result behind a valid/ready handshake.
- Two modes: fixed select, driven by the control unit, or round-robin arbitration between requesting sources.
- Used between the register-file, ALU and memory write-back sources, and wherever multiple producers share one consumer.

Parameters:
- WIDTH, 32, data width of each channel.
- N_IN, 4, number of input channels (2..16).
- SEL_W, 2, width of sel and out_src; must be at least ceil(log2(N_IN)).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = fixed select via sel; 1 = round-robin arbitration.
- sel  in  SEL_W  channel index used when mode = 0.
- in_data  in  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel request/valid.
- in_ready  out  N_IN  per-channel accept; at most one bit set per cycle.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  out_data/out_src hold a valid word.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid = 0, out_data = 0, out_src = 0, round-robin pointer rr_ptr = 0.
  - in_ready is combinational and therefore 0 while reset is asserted.
- One output register stage, latency 1 cycle.
  - The register can load when load_ok = !out_valid || out_ready.
  - Full throughput: one word per cycle while out_ready is held high.
- Grant (combinational):
  - mode = 0: grant = sel, but only if sel < N_IN and in_valid[sel] = 1. sel >= N_IN never grants; it is not an error and leaves the output register untouched.
  - mode = 1: grant = the first channel with in_valid set, searching rr_ptr, rr_ptr+1, ... wrapping modulo N_IN. No valid channel means no grant.
- in_ready[g] = load_ok && grant_valid for the granted channel g; 0 for all other channels.
- Transfer on input channel g occurs when in_valid[g] && in_ready[g]. At the next rising edge:
  - out_data <= channel g data; out_src <= g; out_valid <= 1.
  - In mode 1 only: rr_ptr <= (g+1) mod N_IN, wrapping from N_IN-1 to 0.
- Output drain when out_valid && out_ready with no new transfer: out_valid <= 0; out_data and out_src hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one with no bubble, and out_valid stays 1.
- Stall (out_valid && !out_ready):
  - out_data, out_src and out_valid hold; all in_ready = 0.
  - rr_ptr holds.
  - Sources must hold their data while waiting.
- rr_ptr is unchanged in mode 0.
- Changing mode or sel affects only the grant of the current cycle; there is no state to flush.
- Fairness: in mode 1, a continuously valid channel is granted at least once every N_IN transfers.
- No arithmetic beyond the modulo-N_IN pointer increment. The increment is computed in SEL_W+1 bits and wrapped by compare, so non-power-of-2 N_IN works.

Test Plan:
1. Reset then idle: all in_valid = 0 -> out_valid = 0, in_ready = 0000, out_data = 0 for 10 cycles.
2. Fixed select, 4x32: mode = 0, sel = 2, in_valid = 1111, ch2 data = 0xCAFE_0002, out_ready = 1.
   - Required: in_ready = 0100; next cycle out_data = 0xCAFE_0002, out_src = 2, out_valid = 1.
   - Then set sel = 5 with N_IN = 6: in_ready[5] = 1; out_src = 5 one cycle later.
3. Round-robin fairness: mode = 1, in_valid = 1111, out_ready = 1 for 8 cycles.
   - Required: out_src sequence 0,1,2,3,0,1,2,3, one word per cycle with no bubbles.
   - Then in_valid = 1010 -> out_src sequence 1,3,1,3.
4. Backpressure: mode = 1, out_ready = 0 after the first word (src 0).
   - Required: out_valid stays 1, out_data stable, in_ready = 0000 for 5 cycles.
   - Release out_ready -> the next word is src 1 with no loss or duplication.
5. Async reset mid-stream: assert reset between clock edges during case 3.
   - Required: out_valid drops immediately, before the next clock edge.
   - After release, the first grant with in_valid = 1111 is src 0 (rr_ptr = 0).
6. Out-of-range and idle: mode = 0, sel = 3 with in_valid = 0111.
   - Required: no grant, in_ready = 0000, out_valid falls after the pending word drains.
   - Switching mode to 1 grants channel rr_ptr in the same cycle.
